window_gen: RTL and testbench

Sliding-window generator sitting directly downstream of the block (line) buffer stage. Each accepted beat is one vertical column of WEIGHTLEN vertically stacked pixels. The block shifts these columns into a WEIGHTLEN x WEIGHTLEN register window and emits a full convolution window to the systolic array whenever the window lies entirely inside one image row band. It tracks column and row position so windows never straddle a row wrap, applies optional stride, and flags the last window of each frame.

---
 rtl/window_gen_if.sv | 19 +
 rtl/window_gen.sv | 143 ++++++++++++++
 tb/tb_window_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_if.sv
// Column-in / window-out stream bundle for window_gen.
// slave is the window_gen side, master is the producer/consumer side.
interface window_gen_if #(
  parameter int WORDWIDTH = 32,
  parameter int WEIGHTLEN = 5
);
  logic [WEIGHTLEN*WORDWIDTH-1:0]           col_in;
  logic                                     in_valid;
  logic                                     in_ready;
  logic [WEIGHTLEN*WEIGHTLEN*WORDWIDTH-1:0] win_out;
  logic                                     out_valid;
  logic                                     out_ready;
  logic                                     out_last;

  modport master (output col_in, in_valid, out_ready,
                  input  in_ready, win_out, out_valid, out_last);
  modport slave  (input  col_in, in_valid, out_ready,
                  output in_ready, win_out, out_valid, out_last);
endinterface

// File: rtl/window_gen.sv
// Sliding KxK window generator fed one image column per beat from the line buffer.
// Optional WINDOW_GEN_STRIDE_EN honours STRIDE; otherwise every in-band position is emitted.
module window_gen #(
  parameter int WORDWIDTH  = 32,
  parameter int FIG_WIDTH  = 28,
  parameter int FIG_HEIGHT = 28,
  parameter int WEIGHTLEN  = 5,
  parameter int STRIDE     = 1
) (
  input logic         clk,
  input logic         rst,
  window_gen_if.slave bus
);
  localparam int K  = WEIGHTLEN;
  localparam int WW = WORDWIDTH;
`ifdef WINDOW_GEN_STRIDE_EN
  localparam int S  = STRIDE;
`else
  localparam int S  = (STRIDE > 0) ? 1 : 1;
`endif
  localparam int LAST_ROW = ((FIG_HEIGHT - K) / S) * S;
  localparam int LAST_COL = K - 1 + ((FIG_WIDTH - K) / S) * S;
  localparam int CW = (FIG_WIDTH > 1) ? $clog2(FIG_WIDTH) : 1;
  localparam int RW = (FIG_HEIGHT > 1) ? $clog2(FIG_HEIGHT) : 1;

  typedef enum logic [1:0] {FILL, RUN, HOLD} state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               col_q, col_d;
  logic [RW-1:0]               row_q, row_d;
  logic [K-1:0][K-1:0][WW-1:0] win_q, win_d;
  logic                        vld_q, vld_d, last_q, last_d;
  logic [K-1:0][WW-1:0]        col;
  logic                        acc, col_wrap, frame_wrap, col_full, ph_ok, emit;

  assign col          = bus.col_in;
  assign bus.in_ready = !vld_q || bus.out_ready;
  assign bus.win_out  = win_q;
  assign bus.out_valid = vld_q;
  assign bus.out_last = last_q;

  assign acc        = bus.in_valid && bus.in_ready;
  assign col_wrap   = (col_q == CW'(FIG_WIDTH - 1));
  assign frame_wrap = col_wrap && (row_q == RW'(FIG_HEIGHT - K));
  // HOLD does not remember whether the band was still filling, so ask the counter
  assign col_full   = (state_q == RUN) || (state_q == HOLD && col_q >= CW'(K - 1));
  assign emit       = acc && col_full && ph_ok;

`ifdef WINDOW_GEN_STRIDE_EN
  localparam int PW = (S > 1) ? $clog2(S) : 1;
  logic [PW-1:0] cph_q, cph_d, rph_q, rph_d;

  always_comb begin
    cph_d = cph_q;
    rph_d = rph_q;
    if (acc) begin
      if (col_wrap) begin
        cph_d = '0;
        if (frame_wrap)                rph_d = '0;
        else if (rph_q == PW'(S - 1))  rph_d = '0;
        else                           rph_d = rph_q + PW'(1);
      end else if (col_q >= CW'(K - 1)) begin
        cph_d = (cph_q == PW'(S - 1)) ? '0 : cph_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cph_q <= '0;
      rph_q <= '0;
    end else begin
      cph_q <= cph_d;
      rph_q <= rph_d;
    end
  end

  assign ph_ok = (cph_q == '0) && (rph_q == '0);
`else
  assign ph_ok = 1'b1;
`endif

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = frame_wrap ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (acc) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = col[K-1-r];
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    if (bus.in_ready) begin
      vld_d  = emit;
      last_d = emit && (row_q == RW'(LAST_ROW)) && (col_q == CW'(LAST_COL));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (acc && col_q == CW'(K - 2)) state_d = RUN;
      RUN:     if (acc && col_wrap)            state_d = FILL;
      HOLD:    if (bus.out_ready)              state_d = (col_d >= CW'(K - 1)) ? RUN : FILL;
      default: state_d = FILL;
    endcase
    if (vld_q && !bus.out_ready) state_d = HOLD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_window_gen.sv
// Randomised bench for window_gen (K=3, 5x5 image) checked against a frame-level window model.
module tb_window_gen;
  localparam int WW  = 32;
  localparam int W   = 5;
  localparam int H   = 5;
  localparam int K   = 3;
  localparam int STR = 2;
`ifdef WINDOW_GEN_STRIDE_EN
  localparam int S = STR;
`else
  localparam int S = 1;
`endif
  localparam int WINW = K*K*WW;
  localparam int COLW = K*WW;
  localparam int NWIN = ((W-K)/S + 1) * ((H-K)/S + 1);
  localparam int BIG  = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  window_gen_if #(.WORDWIDTH(WW), .WEIGHTLEN(K)) bus();

  window_gen #(.WORDWIDTH(WW), .FIG_WIDTH(W), .FIG_HEIGHT(H), .WEIGHTLEN(K), .STRIDE(STR))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [COLW-1:0] col_q[$];
  logic [WINW-1:0] exp_w[$];
  logic            exp_l[$];
  logic [WINW-1:0] got_w[$];
  int              pix[H][W];

  task automatic chk(input string tag, input logic [WINW-1:0] got, input logic [WINW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] el(input logic [WINW-1:0] w, input int r, input int c);
    return w[(r*K + c)*WW +: WW];
  endfunction

  // Model: columns are the image scanned band by band; windows are every stride-aligned
  // KxK block of the image, band order then left to right, last flagged on the final one.
  task automatic build(input int nfr, input bit rnd);
    logic [COLW-1:0] c;
    logic [WINW-1:0] w;
    for (int f = 0; f < nfr; f++) begin
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          pix[y][x] = rnd ? int'($urandom_range(255)) : 16*y + x;
      for (int y0 = 0; y0 <= H-K; y0++)
        for (int x = 0; x < W; x++) begin
          for (int i = 0; i < K; i++) c[i*WW +: WW] = pix[y0+K-1-i][x];
          col_q.push_back(c);
        end
      for (int y0 = 0; y0 <= H-K; y0 += S)
        for (int x0 = 0; x0 <= W-K; x0 += S) begin
          for (int r = 0; r < K; r++)
            for (int cc = 0; cc < K; cc++) w[(r*K + cc)*WW +: WW] = pix[y0+r][x0+cc];
          exp_w.push_back(w);
          exp_l.push_back(1'b0);
        end
      exp_l[exp_l.size()-1] = 1'b1;
    end
  endtask

  task automatic run(input int vprob, input int rprob, input int max_acc, input bit chk_lat);
    int ci = 0, acc = 0, cyc = 0, acc_cyc = -1, first_cyc = -1;
    bit pstall = 0;
    logic [WINW-1:0] pw = '0;
    logic pl = 1'b0;
    logic [COLW-1:0] junk;
    while (cyc < 2000 && acc < max_acc && !(ci >= col_q.size() && exp_w.size() == 0)) begin
      @(negedge clk);
      if (pstall) begin
        chk1("hold_valid", bus.out_valid, 1'b1);
        chk("hold_win", bus.win_out, pw);
        chk1("hold_last", bus.out_last, pl);
      end
      bus.in_valid = (ci < col_q.size()) && ($urandom_range(99) < vprob);
      for (int i = 0; i < K; i++) junk[i*WW +: WW] = $urandom;
      if (bus.in_valid) bus.col_in = col_q[ci];
      else              bus.col_in = junk;
      bus.out_ready = ($urandom_range(99) < rprob);
      #1;
      chk1("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.out_valid && bus.out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk1("window_expected", exp_w.size() > 0, 1'b1);
        if (exp_w.size() > 0) begin
          chk("win", bus.win_out, exp_w.pop_front());
          chk1("last", bus.out_last, exp_l.pop_front());
          got_w.push_back(bus.win_out);
        end
      end
      pstall = bus.out_valid && !bus.out_ready;
      pw     = bus.win_out;
      pl     = bus.out_last;
      if (bus.in_valid && bus.in_ready) begin
        if (ci == K-1) acc_cyc = cyc;
        ci++;
        acc++;
      end
      cyc++;
    end
    chk1("run_in_budget", cyc < 2000, 1'b1);
    if (chk_lat) chk_int("first_latency", first_cyc - acc_cyc, 1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk1("idle_no_valid", bus.out_valid, 1'b0);
    end
  endtask

  task automatic clear_model();
    col_q.delete();
    exp_w.delete();
    exp_l.delete();
    got_w.delete();
  endtask

  task automatic reset_checks();
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_out_last", bus.out_last, 1'b0);
    chk("rst_win_out", bus.win_out, '0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.col_in    = '0;
    repeat (2) @(negedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rst = 1'b0;

    // Ramp image, free-flowing
    build(1, 0);
    run(100, 100, BIG, 1);
    drain(4);
    chk_int("ramp_count", got_w.size(), NWIN);
    if (got_w.size() >= NWIN) begin
      chk("ramp_first_tl", {{(WINW-WW){1'b0}}, el(got_w[0], 0, 0)}, 288'h00);
      chk("ramp_first_tr", {{(WINW-WW){1'b0}}, el(got_w[0], 0, 2)}, 288'h02);
      chk("ramp_first_br", {{(WINW-WW){1'b0}}, el(got_w[0], 2, 2)}, 288'h22);
      chk("ramp_last_tl",  {{(WINW-WW){1'b0}}, el(got_w[NWIN-1], 0, 0)}, 288'h22);
`ifdef WINDOW_GEN_STRIDE_EN
      chk("ramp_win1_tl",  {{(WINW-WW){1'b0}}, el(got_w[1], 0, 0)}, 288'h02);
      chk("ramp_win2_tl",  {{(WINW-WW){1'b0}}, el(got_w[2], 0, 0)}, 288'h20);
`else
      chk("ramp_band1_tl", {{(WINW-WW){1'b0}}, el(got_w[3], 0, 0)}, 288'h10);
`endif
    end
    clear_model();

    // Ramp image with random output back-pressure
    build(1, 0);
    run(100, 55, BIG, 0);
    drain(3);
    chk_int("stall_count", got_w.size(), NWIN);
    clear_model();

    // Reset in the middle of a frame, then a clean frame
    build(1, 0);
    run(100, 100, 7, 0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    reset_checks();
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    build(1, 0);
    run(100, 100, BIG, 1);
    drain(3);
    chk_int("post_rst_count", got_w.size(), NWIN);
    clear_model();

    // Two ramp frames back to back
    build(2, 0);
    run(100, 100, BIG, 1);
    drain(3);
    chk_int("b2b_count", got_w.size(), 2*NWIN);
    clear_model();

    // Random pixels, random valid and ready, three frames
    build(3, 1);
    run(65, 50, BIG, 0);
    drain(3);
    chk_int("rand_count", got_w.size(), 3*NWIN);
    clear_model();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
